// File: rtl/pipeline_seq_ctrl.sv
// Pipeline sequencing controller: free-run, step bursts, stall/flush steering
// and halt drain for an N-stage in-order pipeline.
module pipeline_seq_ctrl #(
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned NB_STEP  = 8,
  parameter int unsigned NB_CYC   = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_step,
  input  logic [NB_STEP-1:0]  i_step_count,
  input  logic                i_stall_req,
  input  logic                i_flush_req,
  input  logic                i_halt_dec,
  output logic [N_STAGES-1:0] o_stage_en,
  output logic                o_bubble,
  output logic                o_flush,
  output logic [N_STAGES-1:0] o_valid,
  output logic [2:0]          o_state,
  output logic                o_halt,
  output logic [NB_CYC-1:0]   o_cycle_cnt
);

  localparam int unsigned NB_DRAIN = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [NB_STEP-1:0]   step_cnt, step_cnt_nxt;
  logic [NB_DRAIN-1:0]  drain_cnt, drain_cnt_nxt;
  logic [N_STAGES-1:0]  valid_nxt;
  logic                 advance;
  logic                 halt_go;

  assign o_state = 3'(state);
  assign halt_go = i_halt_dec && o_valid[1] && !i_stall_req;

  // Next-state, stage enables and valid propagation
  always_comb begin
    state_nxt     = state;
    step_cnt_nxt  = step_cnt;
    drain_cnt_nxt = drain_cnt;
    valid_nxt     = o_valid;
    o_stage_en    = '0;
    o_bubble      = 1'b0;
    o_flush       = 1'b0;
    advance       = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_run) begin
          state_nxt = S_RUN;
        end else if (i_step) begin
          state_nxt    = S_STEP;
          step_cnt_nxt = (i_step_count == '0) ? NB_STEP'(1) : i_step_count;
        end
      end

      S_RUN, S_STEP: begin
        advance    = 1'b1;
        o_stage_en = '1;
        if (i_stall_req) begin
          // Hold PC and IF/ID, inject a bubble into ID/EX, let the back end drain
          o_stage_en[1:0] = 2'b00;
          o_bubble        = 1'b1;
          valid_nxt[2]    = 1'b0;
          for (int k = 3; k < int'(N_STAGES); k++) begin
            valid_nxt[k] = o_valid[k-1];
          end
        end else begin
          valid_nxt = {o_valid[N_STAGES-2:0], 1'b1};
          if (i_flush_req) begin
            o_flush      = 1'b1;
            valid_nxt[1] = 1'b0;
          end
        end

        if (state == S_STEP) begin
          step_cnt_nxt = step_cnt - NB_STEP'(1);
        end

        if (halt_go) begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = NB_DRAIN'(N_STAGES - 2);
        end else if (state == S_RUN && !i_run) begin
          state_nxt = S_IDLE;
        end else if (state == S_STEP && step_cnt == NB_STEP'(1)) begin
          state_nxt = S_IDLE;
        end
      end

      S_DRAIN: begin
        advance       = 1'b1;
        o_stage_en    = '1;
        o_stage_en[0] = 1'b0;
        valid_nxt     = {o_valid[N_STAGES-2:0], 1'b0};
        drain_cnt_nxt = drain_cnt - NB_DRAIN'(1);
        if (drain_cnt == NB_DRAIN'(1)) begin
          state_nxt = S_HALTED;
        end
      end

      S_HALTED: begin
        state_nxt = S_HALTED;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered status
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      step_cnt    <= '0;
      drain_cnt   <= '0;
      o_valid     <= '0;
      o_halt      <= 1'b0;
      o_cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      step_cnt  <= step_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      o_valid   <= valid_nxt;
      o_halt    <= (state_nxt == S_HALTED);
      if (advance && o_cycle_cnt != '1) begin
        o_cycle_cnt <= o_cycle_cnt + NB_CYC'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Randomized bench for pipeline_seq_ctrl against a behavioural model of the
// sequencing rules; a second instance with a 4-bit cycle counter covers saturation.
module tb_pipeline_seq_ctrl;

  localparam int unsigned N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         run, step, stall, flush, halt_dec;
  logic [7:0]   step_count;

  logic [N-1:0] stage_en, valid, stage_en4, valid4;
  logic         bubble, flush_o, halt_o, bubble4, flush4, halt4;
  logic [2:0]   state_o, state4;
  logic [31:0]  cyc;
  logic [3:0]   cyc4;

  int checks = 0;
  int errors = 0;

  // Model: pipeline mode, per-stage occupancy, remaining burst/drain cycles
  int       m_mode;
  bit       m_occ[N];
  int       m_step_left, m_drain_left;
  longint   m_adv;
  bit       m_halt;
  bit       known = 0;

  always #5 clk = ~clk;

  pipeline_seq_ctrl #(.N_STAGES(N), .NB_STEP(8), .NB_CYC(32)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_step(step),
    .i_step_count(step_count), .i_stall_req(stall), .i_flush_req(flush),
    .i_halt_dec(halt_dec), .o_stage_en(stage_en), .o_bubble(bubble),
    .o_flush(flush_o), .o_valid(valid), .o_state(state_o), .o_halt(halt_o),
    .o_cycle_cnt(cyc)
  );

  pipeline_seq_ctrl #(.N_STAGES(N), .NB_STEP(8), .NB_CYC(4)) u_dut_c4 (
    .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_step(step),
    .i_step_count(step_count), .i_stall_req(stall), .i_flush_req(flush),
    .i_halt_dec(halt_dec), .o_stage_en(stage_en4), .o_bubble(bubble4),
    .o_flush(flush4), .o_valid(valid4), .o_state(state4), .o_halt(halt4),
    .o_cycle_cnt(cyc4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] occ_vec();
    logic [N-1:0] v;
    for (int k = 0; k < int'(N); k++) v[k] = m_occ[k];
    return v;
  endfunction

  task automatic check_all();
    bit adv, stalled;
    logic [N-1:0] en;
    adv     = (m_mode == 1 || m_mode == 2 || m_mode == 3);
    stalled = (m_mode == 1 || m_mode == 2) && stall;
    en = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (adv && !(m_mode == 3 && k == 0) && !(stalled && k < 2)) en[k] = 1'b1;
    end
    check_eq("stage_en", 64'(stage_en), 64'(en));
    check_eq("bubble",   64'(bubble),   64'(stalled));
    check_eq("flush",    64'(flush_o),  64'((m_mode == 1 || m_mode == 2) && !stall && flush));
    check_eq("valid",    64'(valid),    64'(occ_vec()));
    check_eq("state",    64'(state_o),  64'(m_mode));
    check_eq("halt",     64'(halt_o),   64'(m_halt));
    check_eq("cycle_cnt",  64'(cyc),  64'(m_adv));
    check_eq("cycle_cnt4", 64'(cyc4), 64'((m_adv > 15) ? 15 : m_adv));
  endtask

  task automatic model_clock();
    bit prev[N];
    bit adv;
    if (!rst_n) begin
      m_mode = 0; m_step_left = 0; m_drain_left = 0; m_adv = 0; m_halt = 0;
      foreach (m_occ[k]) m_occ[k] = 0;
      known = 1;
      return;
    end
    adv  = (m_mode == 1 || m_mode == 2 || m_mode == 3);
    prev = m_occ;
    case (m_mode)
      0: begin
        if (run) m_mode = 1;
        else if (step) begin
          m_mode = 2;
          m_step_left = (step_count == 0) ? 1 : int'(step_count);
        end
      end
      1, 2: begin
        if (stall) begin
          m_occ[2] = 0;
          for (int k = 3; k < int'(N); k++) m_occ[k] = prev[k-1];
        end else begin
          m_occ[0] = 1;
          for (int k = 1; k < int'(N); k++) m_occ[k] = prev[k-1];
          if (flush) m_occ[1] = 0;
        end
        if (m_mode == 2) m_step_left--;
        if (halt_dec && prev[1] && !stall) begin
          m_mode = 3; m_drain_left = N - 2;
        end else if (m_mode == 1 && !run) m_mode = 0;
        else if (m_mode == 2 && m_step_left == 0) m_mode = 0;
      end
      3: begin
        m_occ[0] = 0;
        for (int k = 1; k < int'(N); k++) m_occ[k] = prev[k-1];
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 4;
      end
      default: ;
    endcase
    if (adv) m_adv++;
    m_halt = (m_mode == 4);
  endtask

  task automatic tick(input logic r, input logic ru, input logic st, input logic [7:0] sc,
                      input logic sl, input logic fl, input logic hd);
    rst_n = r; run = ru; step = st; step_count = sc; stall = sl; flush = fl; halt_dec = hd;
    #1;
    if (known) check_all();
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; run = 0; step = 0; step_count = 0; stall = 0; flush = 0; halt_dec = 0;
    @(negedge clk);
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);

    // Free run long enough to fill the pipe and saturate the narrow counter
    for (int i = 0; i < 22; i++) tick(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)  tick(1, 0, 0, 0, 0, 0, 0);

    // Step bursts of 3 and of 0 (treated as 1)
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 1, 8'd3, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 1, 8'd7, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 1, 8'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 0, 0);

    // Stall and flush together, then flush alone
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 1, 1, 0);
    tick(1, 1, 0, 0, 0, 1, 0);
    tick(1, 1, 0, 0, 0, 0, 0);

    // Halt into drain and halted; run toggling must not matter
    tick(1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) tick(1, i % 2 == 0, i % 3 == 0, 8'd2, i % 2 == 1, 1, 1);

    // Reset in the middle of a drain
    tick(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets
    begin
      logic r_run;
      r_run = 0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 9) == 0) r_run = ~r_run;
        tick(($urandom_range(0, (m_mode == 4) ? 6 : 80) != 0),
             r_run,
             ($urandom_range(0, 7) == 0),
             8'($urandom_range(0, 5)),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 24) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_seq_ctrl.md
PIPELINE_SEQ_CTRL -- requirements
Module: pipeline_seq_ctrl

Interface
REQ-001 SHALL have parameter N_STAGES, default 5, number of pipeline stages (stage 0 = IF ... stage N_STAGES-1 = WB), legal range 3..8.
REQ-002 SHALL have parameter NB_STEP, default 8, width of step-count input.
REQ-003 SHALL have parameter NB_CYC, default 32, width of cycle counter.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_run  input  1  level; 1 = free-run request from debug unit.
REQ-007 SHALL have port i_step  input  1  one-cycle pulse; start a step burst.
REQ-008 SHALL have port i_step_count  input  NB_STEP  cycles per step burst; 0 treated as 1.
REQ-009 SHALL have port i_stall_req  input  1  load-use stall from hazard unit.
REQ-010 SHALL have port i_flush_req  input  1  taken branch/jump flush from hazard unit.
REQ-011 SHALL have port i_halt_dec  input  1  halt opcode decoded in stage 1 (ID).
REQ-012 SHALL have port o_stage_en  output  N_STAGES  per-stage clock enable; bit 0 = PC, bit k = register feeding stage k.
REQ-013 SHALL have port o_bubble  output  1  clear register feeding stage 2 (ID/EX).
REQ-014 SHALL have port o_flush  output  1  clear register feeding stage 1 (IF/ID).
REQ-015 SHALL have port o_valid  output  N_STAGES  registered per-stage valid bits.
REQ-016 SHALL have port o_state  output  3  current FSM state encoding.
REQ-017 SHALL have port o_halt  output  1  registered; 1 while HALTED.
REQ-018 SHALL have port o_cycle_cnt  output  NB_CYC  count of advance cycles since reset.

Function
REQ-019 SHALL implement FSM states IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4; o_state = registered state.
REQ-020 IDLE: o_stage_en all 0; i_run=1 -> RUN; else i_step=1 -> STEP with step counter loaded max(i_step_count,1); i_run and i_step together -> RUN.
REQ-021 An "advance cycle" is any cycle in RUN, STEP or DRAIN; o_stage_en, o_bubble, o_flush are combinational from registered state and current requests, and are 0 outside advance cycles.
REQ-022 Advance cycle, no stall: o_stage_en all 1; o_valid[k] <= o_valid[k-1] for k>=1; o_valid[0] <= 1 in RUN/STEP.
REQ-023 Advance cycle with i_stall_req=1 (RUN/STEP only): o_stage_en[0]=o_stage_en[1]=0, others 1; o_bubble=1; o_valid[0..1] hold; o_valid[2] <= 0; o_valid[k>=3] shift.
REQ-024 i_flush_req=1 with no stall in RUN/STEP: o_flush=1; o_valid[1] <= 0; stall has priority, flush ignored (o_flush=0) when both asserted.
REQ-025 RUN: i_run=0 -> IDLE next cycle (the current cycle still advances).
REQ-026 STEP: step counter decrements each advance cycle; transition to IDLE on the cycle it reaches 0; i_run/i_step ignored in STEP.
REQ-027 i_halt_dec=1 with o_valid[1]=1 and no stall, in RUN or STEP -> DRAIN, drain counter loaded N_STAGES-2; halt takes priority over i_run=0 and step expiry.
REQ-028 DRAIN: o_stage_en[0]=0 (PC frozen), others 1; o_valid[0] <= 0; i_stall_req, i_flush_req, i_run, i_step ignored; drain counter decrements each cycle; at 0 -> HALTED.
REQ-029 HALTED: o_stage_en all 0, o_halt=1, o_valid holds; exits only via reset.
REQ-030 o_cycle_cnt SHALL increment by 1 on every advance cycle (including stall and DRAIN), saturating at 2^NB_CYC-1.

Reset
REQ-031 With i_reset=0 at a rising edge: state IDLE, o_valid=0, step/drain counters 0, o_cycle_cnt=0, o_halt=0; combinational outputs o_stage_en=0, o_bubble=0, o_flush=0 follow from IDLE.
REQ-032 Reset SHALL take priority in every state, including mid-STEP and mid-DRAIN; no request is remembered across reset.

Verification (N_STAGES=5)
REQ-033 Reset then i_run=1 for 6 cycles -> o_stage_en=5'b11111 each cycle, o_valid=5'b11111 after cycle 5, o_cycle_cnt=6.
REQ-034 IDLE, i_step pulse with i_step_count=3 -> exactly 3 advance cycles, return to IDLE, o_cycle_cnt=3; i_step_count=0 -> exactly 1 advance cycle.
REQ-035 RUN, i_stall_req=1 and i_flush_req=1 same cycle -> o_stage_en=5'b11100, o_bubble=1, o_flush=0, o_valid[2]=0 next cycle.
REQ-036 RUN, i_halt_dec=1 with o_valid[1]=1 -> DRAIN for 3 cycles with o_stage_en=5'b11110, then o_state=4, o_halt=1, o_stage_en=0; i_run toggling has no effect afterward.
REQ-037 i_reset=0 asserted during DRAIN -> next cycle o_state=0, o_valid=0, o_halt=0, o_cycle_cnt=0.
REQ-038 NB_CYC=4, run 20 cycles -> o_cycle_cnt saturates at 15.
